// File: rtl/frame_mem_arbiter_if.sv
// frame_mem_arbiter_if
// Bundles the requester-side handshake and the single-port memory bus that
// the frame arbiter sits between.
//   req / req_we / req_addr / req_wdata : per-requester request (packed, requester i
//                                          at slice i of each vector)
//   ack / rdata                          : one-hot completion pulse and read data
//   mem_addr / mem_wdata / mem_we /
//   mem_re / mem_rdata                   : single-port memory strobes and data
// Modports:
//   master : the arbiter's view (drives ack, rdata and the memory strobes)
//   slave  : the environment's view (requesters plus the memory itself)
interface frame_mem_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_we;
  logic                      mem_re;
  logic [DATA_W-1:0]         mem_rdata;

  modport master (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output ack, rdata, mem_addr, mem_wdata, mem_we, mem_re
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  ack, rdata, mem_addr, mem_wdata, mem_we, mem_re
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter
// Shares one single-port memory between NUM_REQ requesters using a fixed
// four-cycle frame: ARB, SETUP, WRITE strobe, READ strobe. One access is
// granted per frame, round-robin, and completion is signalled by a one-cycle
// ack in the ARB cycle of the following frame.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst   : asynchronous active-high reset
//   bus   : frame_mem_arbiter_if.master (requester handshake + memory bus)
//   phase : current frame phase, 0 straight after reset, then 1..4
//   busy  : a granted access is in flight (phases 2..4 of a granted frame)
module frame_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  frame_mem_arbiter_if.master bus,
  output logic [2:0]          phase,
  output logic                busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    PH_RESET = 3'd0,
    PH_ARB   = 3'd1,
    PH_SETUP = 3'd2,
    PH_WRITE = 3'd3,
    PH_READ  = 3'd4
  } phase_e;

  phase_e             state_q;
  phase_e             state_d;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic [IDX_W-1:0]   next_ptr;

  logic [IDX_W-1:0]   rr_ptr;
  logic               grant_valid;
  logic               grant_we;
  logic [IDX_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] ack_q;

  logic               mem_we_d;
  logic               mem_re_d;
  logic               busy_d;

  // Frame phase register. Reset parks the frame at phase 0 so an in-flight
  // access and its strobes vanish at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PH_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Phase sequencing plus the strobes that belong to each phase. Strobes
  // are decoded from the phase, so a mid-frame reset drops them immediately.
  always_comb begin
    state_d  = state_q;
    mem_we_d = 1'b0;
    mem_re_d = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      PH_RESET: state_d = PH_ARB;
      PH_ARB:   state_d = PH_SETUP;
      PH_SETUP: begin
        state_d = PH_WRITE;
        busy_d  = grant_valid;
      end
      PH_WRITE: begin
        state_d  = PH_READ;
        busy_d   = grant_valid;
        mem_we_d = grant_valid && grant_we;
      end
      PH_READ: begin
        state_d  = PH_ARB;
        busy_d   = grant_valid;
        mem_re_d = grant_valid && !grant_we;
      end
      default:  state_d = PH_ARB;
    endcase
  end

  // Round-robin search starting at the pointer. A requester whose ack is
  // showing this cycle is masked, so a continuous requester cannot win two
  // frames in a row.
  always_comb begin
    eligible  = bus.req & ~ack_q;
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && eligible[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
    next_ptr = IDX_W'((int'(win_idx) + 1) % NUM_REQ);
  end

  // Grant capture, memory address/data hold, completion and read capture.
  // The grant is latched at the end of ARB, the ack and read data land at
  // the end of READ so they are visible during the next frame's ARB cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      grant_valid <= 1'b0;
      grant_we    <= 1'b0;
      grant_idx   <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ack_q       <= '0;
    end else begin
      case (state_q)
        PH_ARB: begin
          ack_q       <= '0;
          grant_valid <= win_found;
          if (win_found) begin
            grant_idx <= win_idx;
            grant_we  <= bus.req_we[win_idx];
            addr_q    <= bus.req_addr[win_idx*ADDR_W +: ADDR_W];
            wdata_q   <= bus.req_wdata[win_idx*DATA_W +: DATA_W];
            rr_ptr    <= next_ptr;
          end
        end
        PH_READ: begin
          grant_valid <= 1'b0;
          if (grant_valid) begin
            ack_q <= NUM_REQ'(1) << grant_idx;
            if (!grant_we) begin
              rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: begin
          ack_q <= ack_q;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_re    = mem_re_d;
  assign phase         = state_q;
  assign busy          = busy_d;

  // Structural guarantees of the frame: never both strobes, never more
  // than one ack at a time.
  assert property (@(posedge clk) disable iff (rst) !(mem_we_d && mem_re_d));
  assert property (@(posedge clk) disable iff (rst) $onehot0(ack_q));

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb_frame_mem_arbiter
// Self-checking bench for frame_mem_arbiter. A behavioural memory answers the
// memory bus; expected accesses are queued as requests are raised and are
// checked against the strobes and acks the arbiter produces.
module tb_frame_mem_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;

  typedef struct {
    logic [NUM_REQ-1:0] ack;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;
  } item_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] phase;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2:0] model_phase;
  item_t sb[$];

  logic [DATA_W-1:0] mem [256];
  logic mem_ready = 1'b0;

  frame_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  frame_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .phase (phase),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: fixed pattern (A000 | addr) with 0x3C holding 0x1234.
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < 256; a++) mem[a] <= 16'hA000 | 16'(a);
      mem[8'h3C] <= 16'h1234;
      mem_ready  <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  // Expected frame phase: 0 in reset, then 1,2,3,4,1,...
  always @(posedge clk or posedge rst) begin
    if (rst) model_phase <= 3'd0;
    else     model_phase <= (model_phase == 3'd0 || model_phase == 3'd4) ? 3'd1 : model_phase + 3'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_expect(input int i, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata);
    item_t it;
    it.ack   = NUM_REQ'(1) << i;
    it.we    = we;
    it.addr  = addr;
    it.wdata = wdata;
    it.rdata = mem[addr];
    sb.push_back(it);
  endtask

  task automatic applyStimulus(input int i, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    bus.req_we[i]                   = we;
    bus.req_addr[i*ADDR_W +: ADDR_W] = addr;
    bus.req_wdata[i*DATA_W +: DATA_W] = wdata;
    bus.req[i]                      = 1'b1;
    push_expect(i, we, addr, wdata);
  endtask

  task automatic wait_phase(input logic [2:0] p);
    logic hit = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (phase == p) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("phase_wait", 32'(hit), 32'd1);
  endtask

  task automatic wait_ack(input int i, input logic drop);
    logic hit = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.ack[i]) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("ack_wait", 32'(hit), 32'd1);
    if (drop) bus.req[i] = 1'b0;
  endtask

  // Monitor: phase sequence, strobe legality and scoreboard comparison.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("phase", 32'(phase), 32'(model_phase));
      checkOutput("strobe_overlap", 32'(bus.mem_we & bus.mem_re), 32'd0);
      if (bus.mem_we) begin
        checkOutput("we_phase", 32'(phase), 32'd3);
        if (sb.size() == 0) checkOutput("unexp_we_sbdepth", 32'(sb.size()), 32'd1);
        else begin
          checkOutput("we_kind", 32'(sb[0].we), 32'd1);
          checkOutput("we_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
          checkOutput("we_data", 32'(bus.mem_wdata), 32'(sb[0].wdata));
        end
      end
      if (bus.mem_re) begin
        checkOutput("re_phase", 32'(phase), 32'd4);
        if (sb.size() == 0) checkOutput("unexp_re_sbdepth", 32'(sb.size()), 32'd1);
        else begin
          checkOutput("re_kind", 32'(sb[0].we), 32'd0);
          checkOutput("re_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
        end
      end
      if (bus.ack != '0) begin
        if (sb.size() == 0) checkOutput("unexp_ack_sbdepth", 32'(sb.size()), 32'd1);
        else begin
          item_t it;
          it = sb.pop_front();
          checkOutput("ack", 32'(bus.ack), 32'(it.ack));
          checkOutput("ack_phase", 32'(phase), 32'd1);
          if (!it.we) checkOutput("rdata", 32'(bus.rdata), 32'(it.rdata));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acks;
    int t_prev;
    rst           = 1'b1;
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);

    // Reset values
    checkOutput("rst_phase", 32'(phase), 32'd0);
    checkOutput("rst_ack", 32'(bus.ack), 32'd0);
    checkOutput("rst_rdata", 32'(bus.rdata), 32'd0);
    checkOutput("rst_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    checkOutput("rst_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rst_re", 32'(bus.mem_re), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Idle frames
    repeat (12) begin
      @(negedge clk);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_ack", 32'(bus.ack), 32'd0);
    end

    // Requester 2 write raised in phase 4
    wait_phase(3'd4);
    applyStimulus(2, 1'b1, 8'h15, 16'hBEEF);
    wait_phase(3'd2);
    checkOutput("t2_addr_p2", 32'(bus.mem_addr), 32'h15);
    checkOutput("t2_busy_p2", 32'(busy), 32'd1);
    checkOutput("t2_we_p2", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    checkOutput("t2_we_p3", 32'(bus.mem_we), 32'd1);
    @(negedge clk);
    checkOutput("t2_we_p4", 32'(bus.mem_we), 32'd0);
    checkOutput("t2_addr_p4", 32'(bus.mem_addr), 32'h15);
    wait_ack(2, 1'b1);
    checkOutput("t2_ack", 32'(bus.ack), 32'b0100);

    // Requester 1 read of 0x3C
    wait_phase(3'd4);
    applyStimulus(1, 1'b0, 8'h3C, 16'h0000);
    wait_phase(3'd3);
    checkOutput("t3_re_p3", 32'(bus.mem_re), 32'd0);
    @(negedge clk);
    checkOutput("t3_re_p4", 32'(bus.mem_re), 32'd1);
    wait_ack(1, 1'b1);
    checkOutput("t3_ack", 32'(bus.ack), 32'b0010);
    checkOutput("t3_rdata", 32'(bus.rdata), 32'h1234);

    // Write with req dropped after grant; rdata must hold across a write
    applyStimulus(0, 1'b1, 8'h3C, 16'h5555);
    wait_phase(3'd2);
    checkOutput("t3b_busy", 32'(busy), 32'd1);
    bus.req[0] = 1'b0;
    wait_ack(0, 1'b0);
    checkOutput("t3b_rdata_hold", 32'(bus.rdata), 32'h1234);
    applyStimulus(3, 1'b0, 8'h3C, 16'h0000);
    wait_ack(3, 1'b1);
    checkOutput("t3b_readback", 32'(bus.rdata), 32'h5555);

    // All four reading continuously from a fresh pointer
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 1'b0, 8'(8'h40 + i), 16'h0000);
    push_expect(0, 1'b0, 8'h40, 16'h0000);
    rst  = 1'b0;
    acks = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.ack != '0) acks++;
      if (acks == 5) break;
    end
    bus.req = '0;
    checkOutput("t4_acks", 32'(acks), 32'd5);

    // Requester 3 alone, continuous: served every other frame
    applyStimulus(3, 1'b0, 8'h50, 16'h0000);
    push_expect(3, 1'b0, 8'h50, 16'h0000);
    push_expect(3, 1'b0, 8'h50, 16'h0000);
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      wait_ack(3, k == 2);
      if (k > 0) checkOutput("t5_gap", 32'(cyc - t_prev), 32'd8);
      t_prev = cyc;
      if (k < 2) begin
        wait_phase(3'd2);
        checkOutput("t5_idle_busy", 32'(busy), 32'd0);
      end
    end

    // Reset in phase 3 of a write, then 0 beats 1
    applyStimulus(0, 1'b1, 8'h77, 16'hCAFE);
    wait_phase(3'd3);
    checkOutput("t6_we_before", 32'(bus.mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_we_rst", 32'(bus.mem_we), 32'd0);
    checkOutput("t6_phase_rst", 32'(phase), 32'd0);
    checkOutput("t6_busy_rst", 32'(busy), 32'd0);
    checkOutput("t6_ack_rst", 32'(bus.ack), 32'd0);
    sb.delete();
    push_expect(0, 1'b1, 8'h77, 16'hCAFE);
    applyStimulus(1, 1'b0, 8'h20, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ack(0, 1'b1);
    wait_ack(1, 1'b1);
    checkOutput("t6_rdata", 32'(bus.rdata), 32'hA020);

    repeat (8) @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
